ibex_mac_seq: RTL
=================

IBEX_MAC_SEQ -- requirements
Module: ibex_mac_seq

Interface
REQ-001 Parameters SHALL be: NUM_TAPS, default 9, number of operand pairs per dot product; ACC_W, default 20, accumulator width; SHIFT, default 0, arithmetic right shift applied before pixel clamp.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 req_valid_i  input  1  job request valid.
REQ-005 req_ready_o  output  1  controller can accept a job.
REQ-006 pixels_i  input  8*NUM_TAPS  signed 8-bit pixels; tap k = bits [8k+7:8k].
REQ-007 coeffs_i  input  8*NUM_TAPS  signed 8-bit coefficients; same packing.
REQ-008 clear_i  input  1  synchronous abort.
REQ-009 mac_operand_a_o  output  8  pixel driven to the MAC datapath.
REQ-010 mac_operand_b_o  output  8  coefficient driven to the MAC datapath.
REQ-011 mac_operator_o  output  4  MAC opcode: 4'b0010 is multiply.
REQ-012 mac_result_i  input  16  signed product returned combinationally by the MAC datapath.
REQ-013 result_valid_o  output  1  result available.
REQ-014 result_ready_i  input  1  consumer accepts the result.
REQ-015 result_acc_o  output  ACC_W  signed accumulated dot product.
REQ-016 result_pix_o  output  8  unsigned clamp of (result_acc_o >>> SHIFT) to 0..255.
REQ-017 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DONE; req_ready_o SHALL be 1 only in IDLE.
REQ-019 In IDLE, req_valid_i=1 at an edge SHALL latch pixels_i and coeffs_i, clear the accumulator and tap index, and move to RUN.
REQ-020 In RUN with tap index k, the block SHALL drive mac_operand_a_o=pixel[k], mac_operand_b_o=coeff[k] and mac_operator_o=4'b0010.
REQ-021 At each edge in RUN, the block SHALL add sign-extended mac_result_i to the accumulator and increment k.
REQ-022 When k=NUM_TAPS-1, the edge SHALL perform the final add and move to DONE.
REQ-023 result_valid_o SHALL first assert exactly NUM_TAPS cycles after the accepting edge.
REQ-024 Outside RUN, mac operands and operator SHALL be 0.
REQ-025 In DONE, result_valid_o=1, and result_acc_o and result_pix_o SHALL remain stable until result_ready_i=1 at an edge; that edge SHALL return the FSM to IDLE.
REQ-026 The block SHALL accept no new job in the DONE-to-IDLE handoff cycle; the next job can be accepted one cycle after the result is taken.
REQ-027 Inputs pixels_i and coeffs_i SHALL be ignored outside the accepting edge; changes during RUN SHALL have no effect.
REQ-028 Accumulation SHALL use two's complement at ACC_W bits; ACC_W >= 16+clog2(NUM_TAPS) SHALL be asserted at elaboration, so overflow cannot occur.
REQ-029 result_pix_o SHALL be 0 if the shifted value is < 0, 255 if it is > 255, and the low 8 bits otherwise.
REQ-030 result_acc_o and result_pix_o SHALL read 0 when not in DONE.
REQ-031 clear_i=1 at an edge SHALL force IDLE and zero the accumulator and index, taking priority over all other transitions, including a same-edge request or result handshake.
REQ-032 Simultaneous req_valid_i and clear_i in IDLE SHALL not accept the job.

Reset
REQ-033 rst_i=1 SHALL immediately force IDLE, zero the accumulator, index and latched operands, and drive every output to 0 except req_ready_o, which SHALL be 1 while rst_i is deasserted and the state is IDLE (0 during reset).
REQ-034 Reset asserted mid-RUN or in DONE SHALL discard the job with no result_valid_o pulse.

Verification
REQ-035 All pixels 1, all coeffs 1 -> result_valid_o exactly 9 cycles after accept; acc=9, pix=9.
REQ-036 All pixels 8'h80, all coeffs 8'h80 -> acc=147456, pix=255.
REQ-037 All pixels 10, all coeffs -1 -> acc=-90, pix=0; with SHIFT=2, pixels 1..9 and coeffs 4 -> acc=180, pix=45.
REQ-038 Hold result_ready_i=0 for 5 cycles in DONE and toggle req_valid_i -> outputs stable, req_ready_o=0; ready=1 -> IDLE next cycle.
REQ-039 clear_i pulse at tap 4, then rst_i pulse mid-RUN on a second job -> IDLE, no result_valid_o, a following job computes correctly.
REQ-040 Check per-tap mac_operand_a_o/b_o ordering against a tap-index scoreboard, and check that operands and operator are zero outside RUN.

Source files
------------

// File: rtl/ibex_mac_seq.sv
// Sequential dot-product controller. It runs NUM_TAPS signed 8x8 products through an
// external MAC datapath, one tap per cycle, and accumulates them. It then presents the
// signed sum and an 8-bit clamped pixel until the consumer takes the result.
module ibex_mac_seq #(
  parameter int unsigned NUM_TAPS = 9,
  parameter int unsigned ACC_W    = 20,
  parameter int unsigned SHIFT    = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [8*NUM_TAPS-1:0]     pixels_i,
  input  logic [8*NUM_TAPS-1:0]     coeffs_i,
  input  logic                      clear_i,
  output logic [7:0]                mac_operand_a_o,
  output logic [7:0]                mac_operand_b_o,
  output logic [3:0]                mac_operator_o,
  input  logic [15:0]               mac_result_i,
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic signed [ACC_W-1:0]   result_acc_o,
  output logic [7:0]                result_pix_o,
  output logic                      busy_o
);

  localparam int unsigned IdxW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [3:0] OpMul = 4'b0010;
  localparam logic signed [ACC_W-1:0] PixMax = ACC_W'(255);

  // The accumulator must hold NUM_TAPS full-range 16-bit products without wrapping.
  if (ACC_W < 16 + $clog2(NUM_TAPS)) begin : g_acc_w_check
    $error("ibex_mac_seq: ACC_W is too narrow for NUM_TAPS products");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q;
  logic [IdxW-1:0]         idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [8*NUM_TAPS-1:0]   pixels_q;
  logic [8*NUM_TAPS-1:0]   coeffs_q;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_shift;
  logic                    last_tap;

  assign prod_ext = ACC_W'($signed(mac_result_i));
  assign last_tap = (idx_q == IdxW'(NUM_TAPS - 1));

  // Control FSM with accumulator. clear_i overrides every transition, including acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      acc_q    <= '0;
      pixels_q <= '0;
      coeffs_q <= '0;
    end else if (clear_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            pixels_q <= pixels_i;
            coeffs_q <= coeffs_i;
            acc_q    <= '0;
            idx_q    <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_q + prod_ext;
          if (last_tap) begin
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (result_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // MAC operand steering: the current tap only while running, zero otherwise.
  always_comb begin
    mac_operand_a_o = '0;
    mac_operand_b_o = '0;
    mac_operator_o  = '0;
    if (state_q == StRun) begin
      mac_operand_a_o = pixels_q[8*idx_q +: 8];
      mac_operand_b_o = coeffs_q[8*idx_q +: 8];
      mac_operator_o  = OpMul;
    end
  end

  assign acc_shift = acc_q >>> SHIFT;

  // Result presentation: outputs are masked to zero except while holding a result.
  always_comb begin
    result_valid_o = (state_q == StDone);
    result_acc_o   = '0;
    result_pix_o   = '0;
    if (state_q == StDone) begin
      result_acc_o = acc_q;
      if (acc_shift[ACC_W-1]) begin
        result_pix_o = 8'd0;
      end else if (acc_shift > PixMax) begin
        result_pix_o = 8'd255;
      end else begin
        result_pix_o = acc_shift[7:0];
      end
    end
  end

  assign busy_o      = (state_q != StIdle);
  // Gate with rst_i so ready drops as soon as reset asserts.
  assign req_ready_o = (state_q == StIdle) && !rst_i;

endmodule
